// File: rtl/interval_timer_bank.sv
`default_nettype none
// ============================================================================
// Module      : interval_timer_bank
// Description : Bank of NUM_CH independent programmable interval timers.
//               Each channel holds a period P loaded at run time. While
//               armed and enabled, a channel counts 0..P and, on the
//               terminal count, raises a done pulse that is stretched to
//               PULSE_W cycles. In one-shot mode the channel then disarms.
//               In auto-reload mode it keeps running.
//
// Ports       : i_clk        - single clock, rising-edge active
//               i_reset      - synchronous active-high clear of every channel
//               i_load       - per-channel strobe: capture i_load_value, arm
//               i_load_value - period value shared by all channels
//               i_enable     - per-channel count enable (low freezes count)
//               i_periodic   - per-channel mode, 1 = auto-reload, 0 = one-shot
//               o_done       - registered terminal-count pulse, PULSE_W wide
//               o_busy       - registered, high while channel is armed
//               o_any_done   - OR of all o_done bits
//
// Revision    : 1.0 - initial release
// ============================================================================
module interval_timer_bank #(
   parameter int NUM_CH  = 4,
   parameter int CNT_W   = 24,
   parameter int PULSE_W = 1
) (
   input  logic              i_clk,
   input  logic              i_reset,
   input  logic [NUM_CH-1:0] i_load,
   input  logic [CNT_W-1:0]  i_load_value,
   input  logic [NUM_CH-1:0] i_enable,
   input  logic [NUM_CH-1:0] i_periodic,
   output logic [NUM_CH-1:0] o_done,
   output logic [NUM_CH-1:0] o_busy,
   output logic              o_any_done
);

   // Stretch counter must hold the value PULSE_W itself.
   localparam int SW = $clog2(PULSE_W + 1);
   localparam logic [SW-1:0] c_STRETCH_LOAD = SW'(PULSE_W);
   localparam logic [SW-1:0] c_STRETCH_ONE  = SW'(1);
   localparam logic [CNT_W-1:0] c_CNT_ONE   = CNT_W'(1);

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   generate
      for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
         state_t           r_state;
         state_t           w_state_nxt;
         logic [CNT_W-1:0] r_period;
         logic [CNT_W-1:0] w_period_nxt;
         logic [CNT_W-1:0] r_count;
         logic [CNT_W-1:0] w_count_nxt;
         logic [SW-1:0]    r_stretch;
         logic [SW-1:0]    w_stretch_nxt;
         logic             r_done;
         logic             r_busy;
         logic             w_terminal;

         // Terminal count: armed, enabled and the counter has reached P.
         assign w_terminal = (r_state == ST_RUN) && i_enable[g] &&
                             (r_count == r_period);

         // ---------------------------------------------------------------
         // State / datapath registers. done and busy are registered from
         // the next-state values so they line up with the stretch counter
         // and the armed state without extra latency.
         // ---------------------------------------------------------------
         always_ff @(posedge i_clk) begin
            if (i_reset) begin
               r_state   <= ST_IDLE;
               r_period  <= '0;
               r_count   <= '0;
               r_stretch <= '0;
               r_done    <= 1'b0;
               r_busy    <= 1'b0;
            end else begin
               r_state   <= w_state_nxt;
               r_period  <= w_period_nxt;
               r_count   <= w_count_nxt;
               r_stretch <= w_stretch_nxt;
               r_done    <= (w_stretch_nxt != '0);
               r_busy    <= (w_state_nxt == ST_RUN);
            end
         end

         // ---------------------------------------------------------------
         // Next-state logic. The stretch counter runs down regardless of
         // state or enable; a load overrides any coincident terminal count
         // (no new pulse) but leaves an active stretch untouched.
         // ---------------------------------------------------------------
         always_comb begin
            w_state_nxt   = r_state;
            w_period_nxt  = r_period;
            w_count_nxt   = r_count;
            w_stretch_nxt = (r_stretch != '0) ? (r_stretch - c_STRETCH_ONE)
                                              : '0;

            if (i_load[g]) begin
               w_period_nxt = i_load_value;
               w_count_nxt  = '0;
               w_state_nxt  = ST_RUN;
            end else if (w_terminal) begin
               // Re-trigger while stretching simply restarts the stretch,
               // so back-to-back events merge into one long pulse.
               w_count_nxt   = '0;
               w_stretch_nxt = c_STRETCH_LOAD;
               if (!i_periodic[g]) begin
                  w_state_nxt = ST_IDLE;
               end
            end else if ((r_state == ST_RUN) && i_enable[g]) begin
               w_count_nxt = r_count + c_CNT_ONE;
            end
         end

         assign o_done[g] = r_done;
         assign o_busy[g] = r_busy;
      end
   endgenerate

   assign o_any_done = |o_done;

endmodule
`default_nettype wire

// File: doc/interval_timer_bank.md
# interval_timer_bank

Parametrised bank of independent programmable interval timers replacing the fixed-count wait/pulse buffers in the frame and pulse timing path. Each channel holds a run-time loadable period, counts enabled clock cycles, and raises a stretched `done` pulse at terminal count, in either one-shot or auto-reload mode. The block sits between the top-level control FSM, which loads and arms channels, and the draw/update logic that consumes `done`.

## Interface
- `NUM_CH`, default 4: number of independent timer channels (≥1).
- `CNT_W`, default 24: width of period register and counter per channel.
- `PULSE_W`, default 1: cycles `done` stays high per terminal-count event (≥1).

- `clk`  in  1  single clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high; clears every channel.
- `load`  in  NUM_CH  per-channel strobe; captures `load_value` and arms the channel.
- `load_value`  in  CNT_W  period value shared by all channels; sampled only where `load[i]` is high.
- `enable`  in  NUM_CH  per-channel count enable; low freezes the counter.
- `periodic`  in  NUM_CH  per-channel mode; 1 = auto-reload, 0 = one-shot. Sampled at terminal count.
- `done`  out  NUM_CH  registered terminal-count pulse, stretched to PULSE_W cycles.
- `busy`  out  NUM_CH  registered; high while the channel is armed (RUN).
- `any_done`  out  1  OR of all `done` bits.

## Operation
- Per channel: period register P, counter C (both CNT_W), state IDLE/RUN, pulse-stretch counter S (width clog2(PULSE_W+1)).
- Reset: P=0, C=0, S=0, state IDLE. `done`=0, `busy`=0, `any_done`=0.
- IDLE: no counting. `enable` is ignored. Leaves IDLE only via `load`.
- `load[i]` in any state: P←load_value, C←0, state←RUN. Any in-flight terminal count that cycle is discarded, but an active `done` stretch continues.
- RUN, `enable[i]`=0: C and state hold.
- RUN, `enable[i]`=1, C≠P: C←C+1.
- RUN, `enable[i]`=1, C==P (terminal): C←0, S←PULSE_W. Then state stays RUN if `periodic[i]`=1, else state←IDLE.
- `done[i]` = (S≠0), registered. S decrements each cycle while nonzero, independent of `enable`/state.
- A new terminal while S≠0 reloads S←PULSE_W. Pulses merge; they are not counted separately.
- P=0 with periodic: terminal on every enabled cycle, so `done` is held continuously while enabled.
- Counter equality compare only. No wrap: C never exceeds P, because load resets C.
- Channels are fully independent. No shared arbitration.
- `any_done` is combinational OR of the registered `done` bits.

## Timing
- Period: terminal occurs on the (P+1)th enabled rising edge after the load edge.
- `done` rises in the cycle after the terminal edge and lasts exactly PULSE_W cycles, absent re-trigger.
- `busy` rises in the cycle after the load edge. In one-shot mode it falls in the same cycle `done` rises.
- Periodic with continuous enable: `done` rising edges are exactly P+1 cycles apart.
- Disabled cycles stretch the period one-for-one. No cycles are lost or gained.
- Reset has priority over `load`. Reset mid-count or mid-pulse clears `done` and `busy` in the next cycle.
- `load` and terminal in the same cycle: load wins, no new `done` generated.
- `reset` and `load` in the same cycle: channel ends IDLE with P=0.

## Test plan
- Reset then idle: hold `reset` 2 cycles, drive random `enable`, no `load` → `done`=0, `busy`=0, `any_done`=0 for 50 cycles.
- One-shot: PULSE_W=1. Load ch0 with 3, `periodic`=0, enable held → `done[0]` high exactly once, 4 cycles after load edge, for 1 cycle. `busy[0]` falls in the same cycle and no further pulses occur.
- Periodic with stall: PULSE_W=3. Load ch1 with 9, `periodic`=1, drop `enable` for 5 cycles mid-period → first `done` 15 cycles after load, then every 10 cycles, each pulse 3 cycles wide.
- Re-trigger merge: PULSE_W=4, P=1, periodic, enable held → `done` stays continuously high.
- Collisions: `load` coinciding with terminal → no pulse, count restarts from 0. `reset` asserted mid-pulse → `done` low the next cycle and `busy` low.
- Channel independence: NUM_CH=4, periods 0/5/7/100 loaded on different cycles → each channel's `done` timing matches its own model, and `any_done` equals the OR of all channels every cycle.
